// File: rtl/mux_n_1_rr_arbiter.sv
// Round-robin burst arbiter that shares one N:1 data mux among 2^LOG2_N streaming requesters.
// Optional macro MUX_ARB_BURST_LIMIT_EN caps each grant at MAX_BURST beats.

module mux_n_1 #(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 2
) (
    input  logic [(1<<LOG2_N)*WIDTH-1:0]          i_data,
    input  logic [((LOG2_N == 0) ? 1 : LOG2_N)-1:0] i_sel,
    output logic [WIDTH-1:0]                      o_data
);
    localparam int N  = 1 << LOG2_N;
    localparam int SW = (LOG2_N == 0) ? 1 : LOG2_N;

    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i_sel == SW'(i)) begin
                o_data = i_data[i*WIDTH +: WIDTH];
            end
        end
    end
endmodule

module mux_n_1_rr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int LOG2_N    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [(1<<LOG2_N)-1:0]                 req_valid,
    input  logic [(1<<LOG2_N)-1:0]                 req_last,
    input  logic [(1<<LOG2_N)*WIDTH-1:0]           req_data,
    output logic [(1<<LOG2_N)-1:0]                 req_ready,
    output logic                                   out_valid,
    output logic                                   out_last,
    output logic [WIDTH-1:0]                       out_data,
    input  logic                                   out_ready,
    output logic [((LOG2_N == 0) ? 1 : LOG2_N)-1:0] sel,
    output logic                                   busy
);
    localparam int N  = 1 << LOG2_N;
    localparam int SW = (LOG2_N == 0) ? 1 : LOG2_N;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   r_ptr;
    logic            r_busy;

    logic [SW-1:0]   w_pick;
    logic [SW-1:0]   w_selNext;
    logic            w_anyValid;
    logic            w_valid;
    logic            w_last;
    logic            w_capHit;
    logic            w_xfer;
    logic            w_endBurst;
    logic [WIDTH-1:0] w_data;

    mux_n_1 #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) u_dataMux (
        .i_data (req_data),
        .i_sel  (r_sel),
        .o_data (w_data)
    );

    mux_n_1 #(.WIDTH(1), .LOG2_N(LOG2_N)) u_validMux (
        .i_data (req_valid),
        .i_sel  (r_sel),
        .o_data (w_valid)
    );

    mux_n_1 #(.WIDTH(1), .LOG2_N(LOG2_N)) u_lastMux (
        .i_data (req_last),
        .i_sel  (r_sel),
        .o_data (w_last)
    );

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        w_pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_pick = SW'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i] && (SW'(i) >= r_ptr)) begin
                w_pick = SW'(i);
            end
        end
    end

    assign w_anyValid = |req_valid;
    assign w_selNext  = (LOG2_N == 0) ? '0 : r_sel + SW'(1);

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] r_beatCnt;

    // The beat that brings the count to MAX_BURST is presented as a last beat.
    assign w_capHit = (r_beatCnt == CW'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_beatCnt <= '0;
        end else if (r_state == IDLE) begin
            r_beatCnt <= '0;
        end else if (w_xfer) begin
            r_beatCnt <= r_beatCnt + CW'(1);
        end
    end
`else
    logic w_unusedMaxBurst;

    assign w_unusedMaxBurst = (MAX_BURST > 0);
    assign w_capHit         = 1'b0;
`endif

    assign out_valid  = (r_state == BUSY) && w_valid;
    assign out_last   = (r_state == BUSY) && (w_last || w_capHit);
    assign out_data   = w_data;
    assign w_xfer     = out_valid && out_ready;
    assign w_endBurst = w_xfer && out_last;
    assign sel        = r_sel;
    assign busy       = r_busy;

    always_comb begin
        req_ready = '0;
        if ((r_state == BUSY) && out_ready) begin
            for (int i = 0; i < N; i++) begin
                if (SW'(i) == r_sel) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyValid) begin
                        r_sel   <= w_pick;
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_endBurst) begin
                        r_ptr   <= w_selNext;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_n_1_rr_arbiter.sv
// Directed testbench for mux_n_1_rr_arbiter (4 requesters, 16-bit data).
// Define MUX_ARB_BURST_LIMIT_EN to also exercise the MAX_BURST=4 beat cap.

module tb_mux_n_1_rr_arbiter;
    localparam int W = 16;
    localparam int N = 4;
`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int MAXB = 4;
`else
    localparam int MAXB = 16;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic          out_last;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [1:0]    sel;
    logic          busy;

    int checks = 0;
    int fails  = 0;

    mux_n_1_rr_arbiter #(.WIDTH(W), .LOG2_N(2), .MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] beatData(int r, int b);
        return W'(16'hA000 + r * 256 + b);
    endfunction

    task automatic driveReq(int r, bit v, bit l, int b);
        req_valid[r] = v;
        req_last[r]  = l;
        req_data[r*W +: W] = beatData(r, b);
    endtask

    task automatic clearReqs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        resetn = 1'b0;
        clearReqs();
        out_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clearReqs();
        out_ready = 1'b1;
        #12;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sel !== 2'd0) begin fails++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_single_burst();
        doReset();
        driveReq(2, 1'b1, 1'b0, 0);
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_idle got valid=%b busy=%b exp 0 0", out_valid, busy); end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            driveReq(2, 1'b1, (b == 3), b);
            #1;
            checks++; if (sel !== 2'd2) begin fails++; $display("FAIL single_sel beat=%0d got=%0d exp=2", b, sel); end
            checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL single_valid beat=%0d got valid=%b busy=%b exp 1 1", b, out_valid, busy); end
            checks++; if (out_data !== beatData(2, b)) begin fails++; $display("FAIL single_data beat=%0d got=%h exp=%h", b, out_data, beatData(2, b)); end
            checks++; if (out_last !== (b == 3)) begin fails++; $display("FAIL single_last beat=%0d got=%b exp=%b", b, out_last, (b == 3)); end
            checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready beat=%0d got=%b exp=0100", b, req_ready); end
        end
        @(negedge clk);
        clearReqs();
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL single_done got busy=%b valid=%b exp 0 0", busy, out_valid); end
        driveReq(0, 1'b1, 1'b1, 0);
        driveReq(3, 1'b1, 1'b1, 0);
        @(negedge clk);
        #1;
        checks++; if (sel !== 2'd3) begin fails++; $display("FAIL single_ptr3 got=%0d exp=3", sel); end
        @(negedge clk);
        driveReq(3, 1'b0, 1'b0, 0);
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_bubble got busy=%b exp=0", busy); end
        @(negedge clk);
        #1;
        checks++; if (sel !== 2'd0 || busy !== 1'b1) begin fails++; $display("FAIL single_wrap got sel=%0d busy=%b exp 0 1", sel, busy); end
        @(negedge clk);
        clearReqs();
    endtask

    task automatic test_round_robin();
        int cnt[N];
        int grants[N];
        int phase;
        int exp;
        for (int r = 0; r < N; r++) begin
            cnt[r] = 0;
            grants[r] = 0;
        end
        doReset();
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            for (int r = 0; r < N; r++) driveReq(r, 1'b1, (cnt[r] == 1), cnt[r]);
            #1;
            phase = c % 3;
            exp = (c / 3) % N;
            if (phase == 0) begin
                checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL rr_bubble cyc=%0d got busy=%b valid=%b exp 0 0", c, busy, out_valid); end
            end else begin
                checks++; if (sel !== 2'(exp)) begin fails++; $display("FAIL rr_sel cyc=%0d got=%0d exp=%0d", c, sel, exp); end
                checks++; if (out_data !== beatData(exp, phase - 1)) begin fails++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", c, out_data, beatData(exp, phase - 1)); end
                checks++; if (out_last !== (phase == 2)) begin fails++; $display("FAIL rr_last cyc=%0d got=%b exp=%b", c, out_last, (phase == 2)); end
                if (phase == 1 && c < 12 && busy === 1'b1) grants[sel]++;
                cnt[exp] ^= 1;
            end
        end
        for (int r = 0; r < N; r++) begin
            checks++; if (grants[r] != 1) begin fails++; $display("FAIL rr_fair req=%0d got=%0d grants exp=1", r, grants[r]); end
        end
        @(negedge clk);
        clearReqs();
    endtask

    task automatic test_backpressure();
        bit [0:3] pat;
        int b;
        int k;
        pat = 4'b1001;
        doReset();
        driveReq(1, 1'b1, 1'b0, 0);
        driveReq(3, 1'b1, 1'b1, 0);
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_idle_ready got=%b exp=0000", req_ready); end
        b = 0;
        k = 0;
        while (b < 4 && k < 20) begin
            @(negedge clk);
            out_ready = pat[k % 4];
            driveReq(1, 1'b1, (b == 3), b);
            #1;
            checks++; if (sel !== 2'd1 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_sel cyc=%0d got sel=%0d valid=%b exp 1 1", k, sel, out_valid); end
            checks++; if (out_data !== beatData(1, b)) begin fails++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", k, out_data, beatData(1, b)); end
            checks++; if (out_last !== (b == 3)) begin fails++; $display("FAIL bp_last cyc=%0d got=%b exp=%b", k, out_last, (b == 3)); end
            checks++; if (req_ready !== (out_ready ? 4'b0010 : 4'b0000)) begin fails++; $display("FAIL bp_ready cyc=%0d got=%b ready_in=%b", k, req_ready, out_ready); end
            if (out_ready) b++;
            k++;
        end
        checks++; if (k != 8) begin fails++; $display("FAIL bp_cycles got=%0d exp=8", k); end
        @(negedge clk);
        out_ready = 1'b1;
        driveReq(1, 1'b0, 1'b0, 0);
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_bubble got busy=%b exp=0", busy); end
        @(negedge clk);
        #1;
        checks++; if (sel !== 2'd3) begin fails++; $display("FAIL bp_next got sel=%0d exp=3", sel); end
        @(negedge clk);
        clearReqs();
    endtask

    task automatic test_stall();
        doReset();
        out_ready = 1'b1;
        driveReq(3, 1'b1, 1'b0, 0);
        @(negedge clk);
        #1;
        checks++; if (sel !== 2'd3 || out_data !== beatData(3, 0)) begin fails++; $display("FAIL stall_first got sel=%0d data=%h exp 3 %h", sel, out_data, beatData(3, 0)); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            driveReq(3, 1'b0, 1'b0, 1);
            driveReq(0, 1'b1, 1'b1, 0);
            #1;
            checks++; if (sel !== 2'd3 || busy !== 1'b1) begin fails++; $display("FAIL stall_hold cyc=%0d got sel=%0d busy=%b exp 3 1", c, sel, busy); end
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_valid cyc=%0d got=%b exp=0", c, out_valid); end
            checks++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL stall_ready cyc=%0d got=%b exp=1000", c, req_ready); end
        end
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            driveReq(3, 1'b1, (b == 3), b);
            #1;
            checks++; if (sel !== 2'd3 || out_data !== beatData(3, b)) begin fails++; $display("FAIL stall_resume beat=%0d got sel=%0d data=%h exp 3 %h", b, sel, out_data, beatData(3, b)); end
            checks++; if (out_last !== (b == 3)) begin fails++; $display("FAIL stall_last beat=%0d got=%b exp=%b", b, out_last, (b == 3)); end
        end
        @(negedge clk);
        driveReq(3, 1'b0, 1'b0, 0);
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL stall_bubble got busy=%b exp=0", busy); end
        @(negedge clk);
        #1;
        checks++; if (sel !== 2'd0 || out_data !== beatData(0, 0)) begin fails++; $display("FAIL stall_wrap got sel=%0d data=%h exp 0 %h", sel, out_data, beatData(0, 0)); end
        @(negedge clk);
        clearReqs();
    endtask

    task automatic test_async_reset();
        doReset();
        out_ready = 1'b1;
        driveReq(2, 1'b1, 1'b1, 0);
        @(negedge clk);
        @(negedge clk);
        driveReq(2, 1'b0, 1'b0, 0);
        driveReq(3, 1'b1, 1'b0, 0);
        @(negedge clk);
        #1;
        checks++; if (sel !== 2'd3 || out_data !== beatData(3, 0)) begin fails++; $display("FAIL ares_beat1 got sel=%0d data=%h exp 3 %h", sel, out_data, beatData(3, 0)); end
        @(negedge clk);
        driveReq(3, 1'b1, 1'b0, 1);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin fails++; $display("FAIL ares_out got valid=%b last=%b exp 0 0", out_valid, out_last); end
        checks++; if (busy !== 1'b0 || sel !== 2'd0) begin fails++; $display("FAIL ares_state got busy=%b sel=%0d exp 0 0", busy, sel); end
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL ares_ready got=%b exp=0000", req_ready); end
        @(negedge clk);
        resetn = 1'b1;
        driveReq(3, 1'b1, 1'b1, 0);
        driveReq(1, 1'b1, 1'b1, 0);
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ares_idle got busy=%b exp=0", busy); end
        @(negedge clk);
        #1;
        checks++; if (sel !== 2'd1) begin fails++; $display("FAIL ares_ptr got sel=%0d exp=1", sel); end
        @(negedge clk);
        clearReqs();
    endtask

`ifdef MUX_ARB_BURST_LIMIT_EN
    task automatic test_burst_limit();
        int cnt0;
        int cnt1;
        int phase;
        int owner;
        int expBeat;
        cnt0 = 0;
        cnt1 = 0;
        doReset();
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            driveReq(0, (cnt0 < 10), (cnt0 == 9), cnt0);
            driveReq(1, (cnt1 < 4), (cnt1 == 3), cnt1);
            #1;
            phase = c % 5;
            owner = ((c / 5) == 1) ? 1 : 0;
            expBeat = ((c / 5) == 2) ? (phase + 3) : (phase - 1);
            if (phase == 0) begin
                checks++; if (busy !== 1'b0) begin fails++; $display("FAIL cap_bubble cyc=%0d got busy=%b exp=0", c, busy); end
            end else begin
                checks++; if (sel !== 2'(owner)) begin fails++; $display("FAIL cap_sel cyc=%0d got=%0d exp=%0d", c, sel, owner); end
                checks++; if (out_data !== beatData(owner, expBeat)) begin fails++; $display("FAIL cap_data cyc=%0d got=%h exp=%h", c, out_data, beatData(owner, expBeat)); end
                checks++; if (out_last !== (phase == 4)) begin fails++; $display("FAIL cap_last cyc=%0d got=%b exp=%b", c, out_last, (phase == 4)); end
                if (owner == 0) cnt0++;
                else cnt1++;
            end
        end
        @(negedge clk);
        clearReqs();
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_stall();
        test_async_reset();
`ifdef MUX_ARB_BURST_LIMIT_EN
        test_burst_limit();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
